piso_shift_tx: RTL and testbench

- Parallel-in serial-out transmitter with selectable shift direction.
- Transmit-side counterpart of the team's 4-bit bidirectional serial-in shift register: it produces the serial stream that register consumes.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per accepted cycle, MSB-first or LSB-first.
- Sits between a parallel data source and a serial link or downstream shift register.

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_shift_tx_if.sv | 27 ++
 rtl/piso_bit_counter.sv | 31 +++
 rtl/piso_shift_tx.sv | 128 ++++++++++++
 tb/tb_piso_shift_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_shift_tx transmitter.
// Optional feature macro: PISO_SHIFT_TX_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  // Number of serial bits per frame for a given data width.
  function automatic int frame_len(input int width);
`ifdef PISO_SHIFT_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial link signals of piso_shift_tx.
// The transmitter uses the slave view; the data source / receiver side uses master.
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             dir;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  load_valid, load_data, dir, ser_ready,
    output load_ready, ser_out, ser_valid, busy, done
  );

  modport master (
    output load_valid, load_data, dir, ser_ready,
    input  load_ready, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: counts accepted bits, flags the final bit of a frame.
// Saturates at the final index so it can never wrap inside a frame.
module piso_bit_counter #(
  parameter int FRAME_LEN = 4,
  localparam int CW = $clog2(FRAME_LEN + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] count;

  assign last = (count == LAST_IDX);

  // Count accepted bits; clear between frames, hold on the last index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, MSB-first or LSB-first per word.
// Optional feature macro: PISO_SHIFT_TX_PARITY_EN (even-parity bit after the data bits).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a word, link idle (ser_out=0, ser_valid=0)
// SHIFT | frame in flight; current bit on ser_out, advances on ser_ready
// DONE  | one-cycle done pulse after the final bit is accepted
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  piso_shift_tx_if.slave  bus
);

  localparam int FRAME_LEN = frame_len(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic             load_acc;
  logic             bit_acc;
  logic             cnt_clr;
  logic             cnt_last;
  logic             data_bit;
  logic             tx_bit;
  logic             ld_ready;
  logic             sv;
  logic             so;
  logic             bz;
  logic             dn;

  assign load_acc = (state == IDLE) && bus.load_valid;
  assign bit_acc  = (state == SHIFT) && bus.ser_ready;
  assign cnt_clr  = (state != SHIFT);

  // The outgoing data bit always sits at the end the frame shifts toward.
  assign data_bit = (dir_q == DIR_LSB_FIRST) ? shreg[0] : shreg[WIDTH-1];

`ifdef PISO_SHIFT_TX_PARITY_EN
  logic parity_q;

  // Parity is computed from the word as loaded, so it is direction independent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (load_acc) begin
      parity_q <= ^bus.load_data;
    end
  end

  // The final frame slot carries the parity bit instead of a data bit.
  assign tx_bit = cnt_last ? parity_q : data_bit;
`else
  assign tx_bit = data_bit;
`endif

  piso_bit_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_bit_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (bit_acc),
    .last    (cnt_last)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    sv        = 1'b0;
    so        = 1'b0;
    bz        = 1'b0;
    dn        = 1'b0;
    case (state)
      IDLE: begin
        ld_ready = 1'b1;
        if (bus.load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        sv = 1'b1;
        so = tx_bit;
        bz = 1'b1;
        if (bus.ser_ready && cnt_last) state_nxt = DONE;
      end
      DONE: begin
        dn        = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch word and direction at load; shift one place per accepted bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else if (load_acc) begin
      shreg <= bus.load_data;
      dir_q <= bus.dir;
    end else if (bit_acc) begin
      if (dir_q == DIR_LSB_FIRST) shreg <= {1'b0, shreg[WIDTH-1:1]};
      else                        shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign bus.load_ready = ld_ready;
  assign bus.ser_valid  = sv;
  assign bus.ser_out    = so;
  assign bus.busy       = bz;
  assign bus.done       = dn;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx (WIDTH=4).
// Optional feature macro: PISO_SHIFT_TX_PARITY_EN (bench expectations follow it).
module tb_piso_shift_tx;

  localparam int W = 4;
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  piso_shift_tx_if #(.WIDTH(W)) bus();

  piso_shift_tx #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Queue-level model: a loaded word becomes a list of pending bits.
  bit   m_q[$];
  logic m_idle = 1'b1;
  logic m_done = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_idle <= 1'b1;
      m_done <= 1'b0;
    end else if (m_idle) begin
      if (bus.load_valid) begin
        for (int i = 0; i < W; i++)
          m_q.push_back(bus.dir ? bus.load_data[i] : bus.load_data[W-1-i]);
`ifdef PISO_SHIFT_TX_PARITY_EN
        m_q.push_back(^bus.load_data);
`endif
        m_idle <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end else if (bus.ser_ready && m_q.size() > 0) begin
      if (m_q.size() == 1) m_done <= 1'b1;
      void'(m_q.pop_front());
    end
  end

  // Compare all outputs with the model every cycle.
  always @(negedge clock) begin
    logic [4:0] exp_v;
    logic [4:0] act_v;
    exp_v = {m_idle, (m_q.size() != 0), (m_q.size() != 0) ? m_q[0] : 1'b0,
             (m_q.size() != 0), m_done};
    act_v = {bus.load_ready, bus.ser_valid, bus.ser_out, bus.busy, bus.done};
    chk("model{ldrdy,sv,so,busy,done}", 32'(act_v), 32'(exp_v));
  end

  // Record bits actually handed over on the link and ser_valid cycles.
  bit cap[$];
  int vcycles = 0;

  always @(posedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus.ser_valid === 1'b1) vcycles++;
      if (bus.ser_valid === 1'b1 && bus.ser_ready === 1'b1) cap.push_back(bus.ser_out);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  function automatic logic [7:0] pack_bits(input int start, input int n);
    logic [7:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[6:0], (start + i < cap.size()) ? cap[start + i] : 1'b0};
    return v;
  endfunction

  logic [7:0] exp_bits;
  logic [7:0] exp_bits2;
  logic [2:0] exp_t;
  int         s0;
  int         s1;
  int         v0;

  initial begin
    reset_n        = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.dir        = 1'b0;
    bus.ser_ready  = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", 32'({bus.load_ready, bus.ser_valid, bus.ser_out, bus.busy, bus.done}),
        32'(5'b10000));
    reset_n = 1'b1;
    tick();

    // 1011 MSB-first: fixed cycle-by-cycle timing and bit order.
    s0 = cap.size();
    bus.load_valid = 1'b1; bus.load_data = 4'b1011; bus.dir = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 1; i <= FL + 2; i++) begin
      exp_t = (i <= FL) ? 3'b100 : (i == FL + 1) ? 3'b010 : 3'b001;
      chk($sformatf("msb_timing_cyc%0d{sv,done,ldrdy}", i),
          32'({bus.ser_valid, bus.done, bus.load_ready}), 32'(exp_t));
      tick();
    end
`ifdef PISO_SHIFT_TX_PARITY_EN
    exp_bits = 8'b10111;
`else
    exp_bits = 8'b1011;
`endif
    chk("msb_1011_bits", 32'(pack_bits(s0, FL)), 32'(exp_bits));
    chk("msb_1011_count", 32'(cap.size() - s0), 32'(FL));

    // 1011 LSB-first with dir toggling mid-frame.
    s0 = cap.size();
    bus.load_valid = 1'b1; bus.load_data = 4'b1011; bus.dir = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    tick(); bus.dir = 1'b0;
    tick(); bus.dir = 1'b1;
    tick(); bus.dir = 1'b0;
    wait_done("lsb");
    tick();
`ifdef PISO_SHIFT_TX_PARITY_EN
    exp_bits = 8'b11011;
`else
    exp_bits = 8'b1101;
`endif
    chk("lsb_1011_bits", 32'(pack_bits(s0, FL)), 32'(exp_bits));

    // 1100 MSB-first with a two-cycle stall on the second bit.
    s0 = cap.size();
    v0 = vcycles;
    bus.load_valid = 1'b1; bus.load_data = 4'b1100; bus.dir = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    tick();
    bus.ser_ready = 1'b0;
    tick();
    chk("stall_hold{sv,so}", 32'({bus.ser_valid, bus.ser_out}), 32'(2'b11));
    tick();
    bus.ser_ready = 1'b1;
    wait_done("stall");
    tick();
`ifdef PISO_SHIFT_TX_PARITY_EN
    exp_bits = 8'b11000;
`else
    exp_bits = 8'b1100;
`endif
    chk("stall_1100_bits", 32'(pack_bits(s0, FL)), 32'(exp_bits));
    chk("stall_valid_cycles", 32'(vcycles - v0), 32'(FL + 2));

    // load_valid held during a frame: ignored until IDLE, then accepted.
    s0 = cap.size();
    bus.load_valid = 1'b1; bus.load_data = 4'b1001; bus.dir = 1'b0;
    tick();
    bus.load_data = 4'b0110;
    chk("busy_ldrdy_low", 32'(bus.load_ready), 32'd0);
    wait_done("hold1");
    chk("done_ldrdy_low", 32'(bus.load_ready), 32'd0);
    tick();
    chk("idle_ldrdy_high", 32'(bus.load_ready), 32'd1);
    tick();
    bus.load_valid = 1'b0;
    s1 = cap.size();
    wait_done("hold2");
    tick();
`ifdef PISO_SHIFT_TX_PARITY_EN
    exp_bits  = 8'b10010;
    exp_bits2 = 8'b01100;
`else
    exp_bits  = 8'b1001;
    exp_bits2 = 8'b0110;
`endif
    chk("hold_first_bits", 32'(pack_bits(s0, FL)), 32'(exp_bits));
    chk("hold_second_bits", 32'(pack_bits(s1, FL)), 32'(exp_bits2));

    // Asynchronous reset while the second bit is shown, then a fresh frame.
    bus.load_valid = 1'b1; bus.load_data = 4'b1011; bus.dir = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        32'({bus.load_ready, bus.ser_valid, bus.ser_out, bus.busy, bus.done}), 32'(5'b10000));
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle{ldrdy,sv}", 32'({bus.load_ready, bus.ser_valid}), 32'(2'b10));
    s0 = cap.size();
    bus.load_valid = 1'b1; bus.load_data = 4'b0101; bus.dir = 1'b0;
    tick();
    bus.load_valid = 1'b0;
    wait_done("fresh");
    tick();
`ifdef PISO_SHIFT_TX_PARITY_EN
    exp_bits = 8'b01010;
`else
    exp_bits = 8'b0101;
`endif
    chk("fresh_0101_bits", 32'(pack_bits(s0, FL)), 32'(exp_bits));
    chk("fresh_0101_count", 32'(cap.size() - s0), 32'(FL));

`ifdef PISO_SHIFT_TX_PARITY_EN
    // Parity bit is zero for an even number of ones.
    s0 = cap.size();
    bus.load_valid = 1'b1; bus.load_data = 4'b1001; bus.dir = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    wait_done("par");
    tick();
    chk("parity_1001_lsb_bits", 32'(pack_bits(s0, FL)), 32'(8'b10010));
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
